clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period and high time of a slow, divided clock (e.g. the output of the team's programmable divider), counted in cycles of the fast system clock `clk`. It sits on the receiving end of a divided-clock line. It synchronises the incoming waveform, reports a fresh measurement on every rising edge, and flags loss of the clock after a programmable timeout. Typical use: self-check and monitoring of divider outputs in lab designs.

## Interface
- `CNT_W`, 16, width of the period and high-time counters and outputs.
- `TIMEOUT`, 4000, number of `clk` cycles without a rising edge before `lost` asserts. Constraint: 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `_rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  synchronous enable; 0 forces IDLE.
- `clk_in`  in  1  measured clock, asynchronous to `clk`.
- `period`  out  CNT_W  last measured period in `clk` cycles.
- `high_time`  out  CNT_W  last measured high time in `clk` cycles.
- `valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `lost`  out  1  level; high while no rising edge has been seen for TIMEOUT cycles.

## Operation
- Front end: a 2-flop synchroniser (`s1`, `s2`), then `s3` for edge detection. `rise = s2 & ~s3`. The level used for high-time counting is `s2`.
- FSM states: IDLE, WAIT_RISE, MEASURE, LOST.
  - IDLE: counters are 0. If `en` = 1, go to WAIT_RISE next cycle.
  - WAIT_RISE: waits for the first `rise`. On `rise`: `cnt` ← 1, `hcnt` ← 1, go to MEASURE. No `valid` is issued.
  - MEASURE: each cycle `cnt` ← `cnt` + 1, and `hcnt` ← `hcnt` + 1 if `s2` = 1.
    - On `rise`: `period` ← `cnt`, `high_time` ← `hcnt`, `valid` = 1, then `cnt` ← 1, `hcnt` ← 1.
    - If `cnt` == TIMEOUT with no `rise` in that cycle, go to LOST.
  - LOST: `lost` = 1. On `rise`: `lost` ← 0, `cnt` ← 1, `hcnt` ← 1, go to MEASURE. No `valid` is issued; the first rise after loss only re-arms.
- `en` = 0 in any state: go to IDLE next cycle. Counters clear, `valid` = 0, `lost` ← 0. `period` and `high_time` hold.
- Counter arithmetic:
  - Counters are CNT_W wide and saturate at all-ones.
  - Because TIMEOUT < 2^CNT_W, saturation is never reached in MEASURE.
  - `hcnt` ≤ `cnt` always.
- Simultaneous events:
  - `rise` in the same cycle as `cnt` == TIMEOUT: the rise wins. A measurement is taken and the FSM stays in MEASURE.
  - `en` falling in the same cycle as `rise`: `en` wins. No `valid` is issued.
- Constant-high `clk_in` has no rises, so it ends in LOST, identical to constant-low.

## Timing
- Reset values: `period` = 0, `high_time` = 0, `valid` = 0, `lost` = 0, state IDLE, `s1`/`s2`/`s3` = 0, `cnt`/`hcnt` = 0.
- Assertion of `_rst` clears all of the above immediately, independent of `clk`, including mid-measurement.
- Latency:
  - `clk_in` first sampled high at edge k → `rise` during cycle k+1..k+2.
  - `valid`, `period` and `high_time` update at edge k+2.
- `lost` rises at the edge where the FSM enters LOST. That edge is TIMEOUT cycles after the last rise was counted (`cnt` = 1).
- `lost` falls at the edge that registers the next `rise`.
- For a clean input of period N and high time H (N, H ≥ 2 `clk` cycles), every `valid` reports exactly N and H. Synchroniser jitter of ±1 is allowed only for inputs asynchronous to `clk`.
- Minimum measurable input: high ≥ 2 and low ≥ 2 `clk` cycles. Faster inputs give undefined values but must not lock up the FSM.

## Structure
- Package `clk_meter_pkg`: `state_t` enum (IDLE, WAIT_RISE, MEASURE, LOST) and the default constants for CNT_W and TIMEOUT.
- Sub-module `sync_edge_det`:
  - Contains the 3-flop synchroniser plus rise detector, with async active-low reset.
  - Outputs `level` (= `s2`) and `rise`.
- Top level holds the FSM, the counters, and the output registers.

## Test plan
- Reset: hold `_rst` = 0 with `clk_in` toggling → `period` = 0, `high_time` = 0, `valid` = 0, `lost` = 0. Release with `en` = 1 → the first rise gives no `valid`.
- Steady input, period 10 and high 5 (synchronous to `clk`) → from the second rise, `valid` pulses every 10 cycles with `period` = 10 and `high_time` = 5.
- Switch to period 1000, high 300 → the first `valid` after the switch reports the boundary period. Every following `valid` reports 1000/300.
- Hold `clk_in` low after a 1000-cycle measurement, TIMEOUT = 4000 → `lost` = 1 exactly 4000 cycles after the last rise, and `period` holds 1000. Restart → the first rise clears `lost` with no `valid`; the second rise gives `valid` with the correct period.
- Drop `en` mid-period, then restore it after 20 cycles → no `valid` and `lost` = 0 while low, outputs hold. After re-enable, the first rise only arms.
- Assert `_rst` asynchronously between `clk` edges mid-measurement → all outputs are 0 before the next `clk` edge.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// ---------------------------------------------------------------------------
// clk_meter_pkg
// Shared definitions for the clock period meter:
//   state_t          - measurement FSM states
//   CNT_W_DEFAULT    - default width of the period / high-time counters
//   TIMEOUT_DEFAULT  - default number of clk cycles without a rising edge
//                      before the measured clock is declared lost
// ---------------------------------------------------------------------------
package clk_meter_pkg;

    localparam int CNT_W_DEFAULT   = 16;
    localparam int TIMEOUT_DEFAULT = 4000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        LOST      = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous slow clock into the clk domain and finds its
// rising edges.
// Ports:
//   clk    in  system clock
//   _rst   in  asynchronous, active-low reset
//   d      in  asynchronous input waveform
//   level  out synchronised level of d (second synchroniser flop)
//   rise   out high for one clk cycle after level goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic _rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 form the metastability synchroniser; s3 is one cycle of
    // history on the clean level so that a 0 -> 1 step can be detected.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/clk_period_meter.sv
// ---------------------------------------------------------------------------
// clk_period_meter
// Measures period and high time of a slow clock in cycles of clk, reports a
// fresh measurement on every rising edge and flags loss of the clock.
// Parameters:
//   CNT_W    width of counters and of period / high_time
//   TIMEOUT  clk cycles without a rising edge before lost asserts
//            (2 <= TIMEOUT <= 2**CNT_W - 1)
// Ports:
//   clk        in  system clock
//   _rst       in  asynchronous, active-low reset
//   en         in  synchronous enable, 0 returns the meter to IDLE
//   clk_in     in  measured clock, asynchronous to clk
//   period     out last measured period
//   high_time  out last measured high time
//   valid      out one-cycle pulse when period / high_time update
//   lost       out high while the measured clock is considered lost
// ---------------------------------------------------------------------------
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             lost
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcnt_inc;
    logic             level;
    logic             rise;

    sync_edge_det u_sync (
        .clk   (clk),
        ._rst  (_rst),
        .d     (clk_in),
        .level (level),
        .rise  (rise)
    );

    // Saturating increments; with TIMEOUT below all-ones the limit is never
    // hit while measuring, but the counters must not wrap to a small value.
    assign cnt_inc  = (cnt  == CNT_MAX) ? cnt  : cnt  + CNT_ONE;
    assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;

    // Measurement FSM. A rise restarts both counters at 1 because the cycle
    // that registers the edge already belongs to the new period (and, as the
    // level is high there, to its high time). Dropping en overrides any
    // edge in the same cycle, and period / high_time only change on valid.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            lost      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                hcnt  <= '0;
                lost  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        hcnt  <= '0;
                        state <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            hcnt  <= CNT_ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period    <= cnt;
                            high_time <= hcnt;
                            valid     <= 1'b1;
                            cnt       <= CNT_ONE;
                            hcnt      <= CNT_ONE;
                        end else if (cnt == TIMEOUT_C) begin
                            state <= LOST;
                            lost  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                            if (level) begin
                                hcnt <= hcnt_inc;
                            end
                        end
                    end
                    LOST: begin
                        if (rise) begin
                            lost  <= 1'b0;
                            cnt   <= CNT_ONE;
                            hcnt  <= CNT_ONE;
                            state <= MEASURE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_period_meter
// Self-checking bench for clk_period_meter. clk_in is driven synchronously
// to clk so every measurement is exact. The reference model keeps the
// sampled input waveform and derives periods, high times, arming and loss
// directly from rising-edge times.
// ---------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 4000;
    localparam int HIST    = 131072;

    logic             clk    = 1'b0;
    logic             _rst   = 1'b1;
    logic             en     = 1'b0;
    logic             clk_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             lost;

    int tests_run    = 0;
    int tests_failed = 0;

    clk_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        ._rst      (_rst),
        .en        (en),
        .clk_in    (clk_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .lost      (lost)
    );

    // 10 time-unit system clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    bit samp_hist [0:HIST-1];
    int edge_count = 0;
    int reset_edge = 0;
    bit m_active   = 1'b0;
    bit m_armed    = 1'b0;
    bit m_lost     = 1'b0;
    bit m_valid    = 1'b0;
    int m_last_rise = 0;
    int m_period   = 0;
    int m_high     = 0;

    // Input value sampled at edge i; anything before the last reset counts
    // as low because the synchroniser is cleared by reset.
    function automatic bit samp_at(input int i);
        if (i < reset_edge || i < 0) return 1'b0;
        return samp_hist[i];
    endfunction

    // A rising input first sampled high at edge k is acted on at edge k+2.
    // Period is the distance between two such edges; high time is the number
    // of high input samples inside that input period.
    always @(posedge clk or negedge _rst) begin
        int  e;
        bit  rise_now;
        if (!_rst) begin
            m_active   = 1'b0;
            m_armed    = 1'b0;
            m_lost     = 1'b0;
            m_valid    = 1'b0;
            m_period   = 0;
            m_high     = 0;
            reset_edge = edge_count;
        end else begin
            e = edge_count;
            samp_hist[e] = clk_in;
            edge_count++;
            rise_now = samp_at(e - 2) && !samp_at(e - 3);
            m_valid = 1'b0;
            if (!en) begin
                m_active = 1'b0;
                m_armed  = 1'b0;
                m_lost   = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
            end else if (rise_now) begin
                if (m_armed && !m_lost) begin
                    m_valid  = 1'b1;
                    m_period = e - m_last_rise;
                    m_high   = 0;
                    for (int j = m_last_rise - 2; j <= e - 3; j++) begin
                        m_high += int'(samp_at(j));
                    end
                end
                m_armed     = 1'b1;
                m_lost      = 1'b0;
                m_last_rise = e;
            end else if (m_armed && !m_lost && (e - m_last_rise) == TIMEOUT) begin
                m_lost = 1'b1;
            end
        end
    end

    // Compare every output against the model half a cycle after each edge.
    always @(negedge clk) begin
        if (_rst) begin
            checkOutput("valid",     64'(valid),     64'(m_valid));
            checkOutput("lost",      64'(lost),      64'(m_lost));
            checkOutput("period",    64'(period),    64'(m_period));
            checkOutput("high_time", 64'(high_time), 64'(m_high));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives reps periods of length n with h high cycles; optionally pulls
    // en low for en_low_len cycles starting at cycle en_low_start.
    task automatic applyStimulus(input int n, input int h, input int reps,
                                 input int en_low_start, input int en_low_len);
        int idx = 0;
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < n; c++) begin
                clk_in = (c < h);
                if (en_low_start >= 0) begin
                    en = !(idx >= en_low_start && idx < en_low_start + en_low_len);
                end
                tick();
                idx++;
            end
        end
        en = 1'b1;
    endtask

    task automatic holdLevel(input bit v, input int cycles);
        clk_in = v;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        int n;
        int h;
        int reps;
        int drop_start;
        int drop_len;
        logic [3:0] phase;

        // Reset held while clk_in toggles: everything stays cleared.
        #2 _rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            phase  = 4'(i);
            clk_in = phase[1];
            tick();
            checkOutput("rstPeriod", 64'(period),    64'd0);
            checkOutput("rstHigh",   64'(high_time), 64'd0);
            checkOutput("rstValid",  64'(valid),     64'd0);
            checkOutput("rstLost",   64'(lost),      64'd0);
        end
        clk_in = 1'b0;
        tick();
        _rst = 1'b1;
        en   = 1'b1;

        // Steady 10/5 input.
        applyStimulus(10, 5, 20, -1, 0);
        checkOutput("steadyPeriod", 64'(period),    64'd10);
        checkOutput("steadyHigh",   64'(high_time), 64'd5);

        // Switch to 1000/300.
        applyStimulus(1000, 300, 4, -1, 0);
        checkOutput("slowPeriod", 64'(period),    64'd1000);
        checkOutput("slowHigh",   64'(high_time), 64'd300);

        // Loss of clock, then restart.
        holdLevel(1'b0, TIMEOUT + 50);
        checkOutput("lostSet",      64'(lost),   64'd1);
        checkOutput("lostPeriod",   64'(period), 64'd1000);
        applyStimulus(1000, 300, 3, -1, 0);
        checkOutput("relockLost",   64'(lost),   64'd0);
        checkOutput("relockPeriod", 64'(period), 64'd1000);

        // Enable dropped mid-period for 20 cycles.
        applyStimulus(40, 15, 4, 55, 20);
        checkOutput("enPeriod", 64'(period),    64'd40);
        checkOutput("enHigh",   64'(high_time), 64'd15);

        // Constant-high input also ends in loss.
        applyStimulus(30, 12, 3, -1, 0);
        holdLevel(1'b1, TIMEOUT + 10);
        checkOutput("lostConstHigh", 64'(lost), 64'd1);
        clk_in = 1'b0;

        // Randomised periods, duty cycles (including too-fast inputs) and
        // enable drops.
        for (int it = 0; it < 150; it++) begin
            n    = int'($urandom_range(2, 80));
            h    = int'($urandom_range(1, n - 1));
            reps = int'($urandom_range(1, 4));
            if ($urandom_range(0, 5) == 0) begin
                drop_start = int'($urandom_range(0, n * reps - 1));
                drop_len   = int'($urandom_range(1, 25));
            end else begin
                drop_start = -1;
                drop_len   = 0;
            end
            applyStimulus(n, h, reps, drop_start, drop_len);
        end

        // Asynchronous reset between clk edges in the middle of a period.
        applyStimulus(50, 20, 3, -1, 0);
        clk_in = 1'b1;
        @(posedge clk);
        #3 _rst = 1'b0;
        #1;
        checkOutput("asyncPeriod", 64'(period),    64'd0);
        checkOutput("asyncHigh",   64'(high_time), 64'd0);
        checkOutput("asyncValid",  64'(valid),     64'd0);
        checkOutput("asyncLost",   64'(lost),      64'd0);
        clk_in = 1'b0;
        tick();
        _rst = 1'b1;
        applyStimulus(30, 10, 4, -1, 0);
        checkOutput("recoverPeriod", 64'(period), 64'd30);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
